alu_seq_nslice: RTL

Parametrised, nibble-serial sequential ALU computing the 16-function, two-mode (logic/arithmetic) operation set of the team's 4-bit combinational ALU over WIDTH bits. One 4-bit slice is reused per cycle with a registered inter-slice carry. Operands enter and results leave through valid/ready handshakes. It sits between the operand register file and the writeback stage of the lab datapath.

---
 rtl/alu_seq_nslice.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_nslice.sv
// alu_seq_nslice: nibble-serial ALU. One 4-bit slice of the 16-function,
// two-mode (logic/arithmetic) ALU is reused once per cycle. The carry between
// slices is kept in a register, so WIDTH bits take N = WIDTH/4 cycles.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE. While waiting for out_ready the result and flags do not change.
//
// Optional feature macro: ALU_SEQ_FLAGS_EN. When it is defined, the zero and
// ovf flags are computed. When it is undefined, both flags are tied to 0 and
// their logic is absent.
//
// The FSM state is kept in state_q (typedef state_t) so that checkers can bind to it.
module alu_seq_nslice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operation and slice-serial working state
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] work_q, work_d;

  // Published result
  logic [WIDTH-1:0] f_q;
  logic             cout_q;

  // Current slice signals
  logic [3:0] sa, sb;
  logic [3:0] sx, sy;
  logic [4:0] sum5;
  logic [3:0] slice_f;
  logic       slice_cout;
  logic       last_slice;

  assign last_slice = (k_q == K_LAST);

  // Select the operand nibbles for slice k
  always_comb begin
    sa = 4'h0;
    sb = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        sa = a_q[4*i +: 4];
        sb = b_q[4*i +: 4];
      end
    end
  end

  // Arithmetic functions are written as x + y + carry. A "-1" term is 4'hF in
  // every slice. Because of this, rippling the carry through the slices gives
  // the full-width result.
  always_comb begin
    sx = sa;
    sy = 4'h0;
    case (s_q)
      4'h0: begin sx = sa;        sy = 4'h0;      end
      4'h1: begin sx = sa | sb;   sy = 4'h0;      end
      4'h2: begin sx = sa | ~sb;  sy = 4'h0;      end
      4'h3: begin sx = 4'hF;      sy = 4'h0;      end
      4'h4: begin sx = sa;        sy = sa & ~sb;  end
      4'h5: begin sx = sa | sb;   sy = sa & ~sb;  end
      4'h6: begin sx = sa;        sy = ~sb;       end
      4'h7: begin sx = sa & ~sb;  sy = 4'hF;      end
      4'h8: begin sx = sa;        sy = sa & sb;   end
      4'h9: begin sx = sa;        sy = sb;        end
      4'hA: begin sx = sa | ~sb;  sy = sa & sb;   end
      4'hB: begin sx = sa & sb;   sy = 4'hF;      end
      4'hC: begin sx = sa;        sy = sa;        end
      4'hD: begin sx = sa | sb;   sy = sa;        end
      4'hE: begin sx = sa | ~sb;  sy = sa;        end
      default: begin sx = sa;     sy = 4'hF;      end
    endcase
  end

  assign sum5 = {1'b0, sx} + {1'b0, sy} + {4'h0, carry_q};

  // Slice result: a logic function of the nibbles, or the arithmetic sum
  always_comb begin
    slice_f    = sum5[3:0];
    slice_cout = sum5[4];
    if (m_q) begin
      slice_cout = 1'b0;
      case (s_q)
        4'h0: slice_f = ~sa;
        4'h1: slice_f = ~(sa | sb);
        4'h2: slice_f = ~sa & sb;
        4'h3: slice_f = 4'h0;
        4'h4: slice_f = ~(sa & sb);
        4'h5: slice_f = ~sb;
        4'h6: slice_f = sa ^ sb;
        4'h7: slice_f = sa & ~sb;
        4'h8: slice_f = ~sa | sb;
        4'h9: slice_f = ~(sa ^ sb);
        4'hA: slice_f = sb;
        4'hB: slice_f = sa & sb;
        4'hC: slice_f = 4'hF;
        4'hD: slice_f = sa | ~sb;
        4'hE: slice_f = sa | sb;
        default: slice_f = sa;
      endcase
    end
  end

  // Merge the current slice into the partial result
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        work_d[4*i +: 4] = slice_f;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Capture the operation, step through the slices, and publish on the last slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      work_q  <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= m ? 1'b0 : cin;
            k_q     <= '0;
          end
        end
        BUSY: begin
          work_q  <= work_d;
          carry_q <= slice_cout;
          k_q     <= last_slice ? '0 : k_q + 1'b1;
          if (last_slice) begin
            f_q    <= work_d;
            cout_q <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign f    = f_q;
  assign cout = cout_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, ovf_q;
  logic slice_c3;

  // The carry into the MSB of a slice is recovered from the sum bit:
  // c3 = x3 ^ y3 ^ sum3. In logic mode this value is forced to 0.
  assign slice_c3 = m_q ? 1'b0 : (sx[3] ^ sy[3] ^ sum5[3]);

  // Flags are computed from the complete result, on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == BUSY && last_slice) begin
      zero_q <= (work_d == '0);
      ovf_q  <= slice_c3 ^ slice_cout;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule
